// File: rtl/add_station_pkg.sv
// Shared constants for the adder reservation stations: default widths, opcodes,
// instruction field positions and the station state encoding.
package add_station_pkg;

   localparam int DFLT_WORD_SIZE = 32;
   localparam int DFLT_RB_SIZE   = 8;
   localparam int DFLT_RB_INDEX  = 3;
   localparam int DFLT_FU_INDEX  = 4;
   localparam int DFLT_REG_INDEX = 5;

   localparam logic [DFLT_FU_INDEX-1:0] NO_FU = '1;

   localparam int OP_WIDTH = 4;
   localparam logic [OP_WIDTH-1:0] INST_ADD  = 4'h1;
   localparam logic [OP_WIDTH-1:0] INST_SUB  = 4'h2;
   localparam logic [OP_WIDTH-1:0] INST_ADDI = 4'h3;
   localparam logic [OP_WIDTH-1:0] INST_SUBI = 4'h4;

   localparam int OP_START  = 28;
   localparam int RD_START  = 23;
   localparam int RS_START  = 18;
   localparam int RT_START  = 13;
   localparam int IMM_WIDTH = 13;

   localparam int ADDER_START = 0;
   localparam int ADDER_NUM   = 2;

   typedef enum logic [1:0] {IDLE, WAIT_OPS, EXEC, BCAST} rs_state_e;

   function automatic logic is_imm_op(input logic [OP_WIDTH-1:0] op);
      return (op == INST_ADDI) || (op == INST_SUBI);
   endfunction

   function automatic logic is_sub_op(input logic [OP_WIDTH-1:0] op);
      return (op == INST_SUB) || (op == INST_SUBI);
   endfunction

endpackage

// File: rtl/add_station_cdb_snoop.sv
// Picks one reorder-buffer slot (value and valid) off the global result bus.
module cdb_snoop #(
   parameter int WORD_SIZE = 32,
   parameter int RB_SIZE   = 8,
   parameter int RB_INDEX  = 3
) (
   input  logic [RB_SIZE*WORD_SIZE-1:0] bus_data,
   input  logic [RB_SIZE-1:0]           bus_valid,
   input  logic [RB_INDEX-1:0]          tag,
   output logic [WORD_SIZE-1:0]         value,
   output logic                         hit
);

   assign value = bus_data[int'(tag)*WORD_SIZE +: WORD_SIZE];
   assign hit   = bus_valid[tag];

endmodule

// File: rtl/add_station.sv
// Adder reservation station + functional unit: accepts one ADD/SUB/ADDI/SUBI,
// waits for operands on CDB_data, executes, broadcasts. ADD_STATION_TRACE_EN enables trace output.
module add_station
   import add_station_pkg::*;
#(
   parameter int WORD_SIZE   = DFLT_WORD_SIZE,
   parameter int RB_SIZE     = DFLT_RB_SIZE,
   parameter int RB_INDEX    = DFLT_RB_INDEX,
   parameter int FU_INDEX    = DFLT_FU_INDEX,
   parameter int REG_INDEX   = DFLT_REG_INDEX,
   parameter int FU_ID       = 0,
   parameter int ADD_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [FU_INDEX-1:0]          CDB_inst_fu,
   input  logic [WORD_SIZE-1:0]         CDB_inst_inst,
   input  logic [RB_INDEX-1:0]          CDB_inst_RBindex,
   output logic [REG_INDEX-1:0]         numj,
   output logic [REG_INDEX-1:0]         numk,
   input  logic [WORD_SIZE-1:0]         vj,
   input  logic [WORD_SIZE-1:0]         vk,
   input  logic [RB_INDEX-1:0]          qj,
   input  logic [RB_INDEX-1:0]          qk,
   input  logic                         qj_pend,
   input  logic                         qk_pend,
   input  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_in,
   input  logic [RB_SIZE-1:0]           CDB_data_valid_in,
   output logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data_out,
   output logic [RB_SIZE-1:0]           CDB_data_valid_out,
   output logic                         busy
);

   localparam int CNT_W = $clog2(ADD_LATENCY + 1);
   localparam logic [FU_INDEX-1:0] MY_FU = FU_INDEX'(FU_ID);
   // Loaded with ADD_LATENCY so the broadcast lands ADD_LATENCY+1 edges after operands are complete.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LATENCY);

   rs_state_e state, state_next;
   logic [OP_WIDTH-1:0]  op, new_op;
   logic [RB_INDEX-1:0]  rb_idx, qj_r, qk_r, tag_j, tag_k;
   logic [WORD_SIZE-1:0] vj_r, vk_r, snoop_j, snoop_k, result, alu, imm_ext;
   logic                 j_rdy, k_rdy, hit_j, hit_k, sel, accept, j_ok, k_ok, new_imm;
   logic [CNT_W-1:0]     cnt;
   logic                 unused_rd;

   assign sel     = (CDB_inst_fu == MY_FU) && !reset && !flush;
   assign accept  = sel && (state == IDLE);
   assign numj    = sel ? CDB_inst_inst[RS_START +: REG_INDEX] : '0;
   assign numk    = sel ? CDB_inst_inst[RT_START +: REG_INDEX] : '0;
   assign new_op  = CDB_inst_inst[OP_START +: OP_WIDTH];
   assign new_imm = is_imm_op(new_op);
   assign imm_ext = WORD_SIZE'(CDB_inst_inst[IMM_WIDTH-1:0]);
   assign unused_rd = ^CDB_inst_inst[RD_START +: REG_INDEX];

   // At issue the snoopers look at the incoming tags (same-cycle bypass), afterwards at the stored ones.
   assign tag_j = (state == IDLE) ? qj : qj_r;
   assign tag_k = (state == IDLE) ? qk : qk_r;

   cdb_snoop #(.WORD_SIZE(WORD_SIZE), .RB_SIZE(RB_SIZE), .RB_INDEX(RB_INDEX)) u_snoop_j (
      .bus_data(CDB_data_data_in), .bus_valid(CDB_data_valid_in), .tag(tag_j),
      .value(snoop_j), .hit(hit_j));
   cdb_snoop #(.WORD_SIZE(WORD_SIZE), .RB_SIZE(RB_SIZE), .RB_INDEX(RB_INDEX)) u_snoop_k (
      .bus_data(CDB_data_data_in), .bus_valid(CDB_data_valid_in), .tag(tag_k),
      .value(snoop_k), .hit(hit_k));

   assign j_ok = !qj_pend || hit_j;
   assign k_ok = new_imm || !qk_pend || hit_k;
   assign alu  = is_sub_op(op) ? (vj_r - vk_r) : (vj_r + vk_r);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (accept) state_next = (j_ok && k_ok) ? EXEC : WAIT_OPS;
         WAIT_OPS: if ((j_rdy || hit_j) && (k_rdy || hit_k)) state_next = EXEC;
         EXEC:     if (cnt == '0) state_next = BCAST;
         BCAST:    state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset or posedge flush) begin
      if (reset || flush) begin
         state  <= IDLE;
         op     <= '0;
         rb_idx <= '0;
         qj_r   <= '0;
         qk_r   <= '0;
         vj_r   <= '0;
         vk_r   <= '0;
         j_rdy  <= 1'b0;
         k_rdy  <= 1'b0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (accept) begin
               op     <= new_op;
               rb_idx <= CDB_inst_RBindex;
               qj_r   <= qj;
               qk_r   <= qk;
               j_rdy  <= j_ok;
               k_rdy  <= k_ok;
               vj_r   <= qj_pend ? snoop_j : vj;
               vk_r   <= new_imm ? imm_ext : (qk_pend ? snoop_k : vk);
               cnt    <= CNT_LOAD;
            end
            WAIT_OPS: begin
               if (!j_rdy && hit_j) begin
                  vj_r  <= snoop_j;
                  j_rdy <= 1'b1;
               end
               if (!k_rdy && hit_k) begin
                  vk_r  <= snoop_k;
                  k_rdy <= 1'b1;
               end
               cnt <= CNT_LOAD;
            end
            EXEC: begin
               if (cnt == '0) result <= alu;
               else           cnt    <= cnt - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

   for (genvar s = 0; s < RB_SIZE; s++) begin : g_slot
      assign CDB_data_valid_out[s] = (state == BCAST) && (rb_idx == RB_INDEX'(s));
      assign CDB_data_data_out[s*WORD_SIZE +: WORD_SIZE] = CDB_data_valid_out[s] ? result : '0;
   end

`ifdef ADD_STATION_TRACE_EN
   always @(posedge clk) begin
      if (!reset && !flush) begin
         if (accept)
            $display("%0t add_station[%0d] accept op=%0h rb=%0d jrdy=%0b krdy=%0b",
                     $realtime, FU_ID, new_op, CDB_inst_RBindex, j_ok, k_ok);
         else if (sel)
            $display("%0t add_station[%0d] issue while busy ignored", $realtime, FU_ID);
         if ((accept && qj_pend && hit_j) || (state == WAIT_OPS && !j_rdy && hit_j))
            $display("%0t add_station[%0d] capture j tag=%0d val=%0h", $realtime, FU_ID, tag_j, snoop_j);
         if ((accept && !new_imm && qk_pend && hit_k) || (state == WAIT_OPS && !k_rdy && hit_k))
            $display("%0t add_station[%0d] capture k tag=%0d val=%0h", $realtime, FU_ID, tag_k, snoop_k);
         if (state == EXEC && cnt == '0)
            $display("%0t add_station[%0d] broadcast slot=%0d result=%0h", $realtime, FU_ID, rb_idx, alu);
      end
   end
   always @(posedge flush)
      $display("%0t add_station[%0d] flush", $realtime, FU_ID);
`endif

endmodule

// File: tb/tb_add_station.sv
// Directed bench for add_station: scoreboard of expected broadcasts checked at negedge.
module tb_add_station;
   import add_station_pkg::*;

   localparam int W = 32, RBS = 8, RBI = 3, FUI = 4, REGI = 5, FU = 2, LAT = 2;

   logic              clk = 1'b0;
   logic              reset, flush;
   logic [FUI-1:0]    inst_fu;
   logic [W-1:0]      inst;
   logic [RBI-1:0]    rbindex;
   logic [REGI-1:0]   numj, numk;
   logic [W-1:0]      vj, vk;
   logic [RBI-1:0]    qj, qk;
   logic              qj_pend, qk_pend;
   logic [RBS*W-1:0]  bus_data, data_out;
   logic [RBS-1:0]    bus_valid, valid_out;
   logic              busy;

   add_station #(.WORD_SIZE(W), .RB_SIZE(RBS), .RB_INDEX(RBI), .FU_INDEX(FUI),
                 .REG_INDEX(REGI), .FU_ID(FU), .ADD_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .CDB_inst_fu(inst_fu), .CDB_inst_inst(inst), .CDB_inst_RBindex(rbindex),
      .numj(numj), .numk(numk), .vj(vj), .vk(vk), .qj(qj), .qk(qk),
      .qj_pend(qj_pend), .qk_pend(qk_pend),
      .CDB_data_data_in(bus_data), .CDB_data_valid_in(bus_valid),
      .CDB_data_data_out(data_out), .CDB_data_valid_out(valid_out), .busy(busy));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int slot; logic [W-1:0] data; int cyc;} exp_t;
   exp_t sb[$];
   int n_checks = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [RBS*W-1:0] obs, input logic [RBS*W-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input int rs, input int rt, input int imm);
      return {op, 5'd3, 5'(rs), 5'(rt), 13'(imm)};
   endfunction

   // Broadcast monitor: every valid_out cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      logic [RBS-1:0]   ev;
      logic [RBS*W-1:0] ed;
      if (!reset && valid_out !== '0) begin
         if (sb.size() == 0) chk("unexpected_bcast", valid_out, '0);
         else begin
            e  = sb.pop_front();
            ev = '0;
            ev[e.slot] = 1'b1;
            ed = '0;
            ed[e.slot*W +: W] = e.data;
            chk("bcast_valid", valid_out, ev);
            chk("bcast_data", data_out, ed);
            chk("bcast_cycle", cyc, e.cyc);
            chk("bcast_busy", busy, 1);
         end
      end
   end

   task automatic issue(input logic [3:0] op, input int rs, input int rt, input int imm, input int rb,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int tj, input int tk,
                        input logic pj, input logic pk, output int acc);
      inst_fu = FU; inst = enc(op, rs, rt, imm); rbindex = RBI'(rb);
      vj = a; vk = b; qj = RBI'(tj); qk = RBI'(tk); qj_pend = pj; qk_pend = pk;
      #1;
      chk("numj", numj, rs);
      chk("numk", numk, rt);
      @(posedge clk); #1;
      acc = cyc;
      inst_fu = NO_FU; qj_pend = 1'b0; qk_pend = 1'b0;
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic drive_slot(input int s, input logic [W-1:0] d);
      bus_data[s*W +: W] = d;
      bus_valid[s] = 1'b1;
   endtask

   task automatic clear_bus();
      bus_data = '0;
      bus_valid = '0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, (busy || sb.size() != 0), 0);
      chk({tag, "_valid"}, valid_out, '0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      reset = 1'b1; flush = 1'b0; inst_fu = NO_FU; inst = '0; rbindex = '0;
      vj = '0; vk = '0; qj = '0; qk = '0; qj_pend = 1'b0; qk_pend = 1'b0;
      clear_bus();
      #2;
      inst_fu = FU; inst = enc(INST_ADD, 9, 10, 0);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_valid", valid_out, '0);
      chk("reset_data", data_out, '0);
      chk("reset_numj", numj, 0);
      inst_fu = NO_FU;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // ready operands: 5 + 7 into slot 4
      issue(INST_ADD, 1, 2, 0, 4, 5, 7, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{4, 32'd12, acc + LAT + 1});
      wait_idle("t1_idle");

      // j pending on tag 6, filled four edges after accept: 10 - 1
      issue(INST_SUB, 6, 7, 0, 1, 0, 1, 6, 0, 1'b1, 1'b0, acc);
      repeat (3) @(posedge clk);
      #1;
      chk("t2_waiting_busy", busy, 1);
      drive_slot(6, 32'd10);
      sb.push_back('{1, 32'd9, acc + 4 + LAT + 1});
      @(posedge clk); #1;
      clear_bus();
      wait_idle("t2_idle");

      // same-cycle bypass on the accept edge: 1 + 0x1FFF
      drive_slot(2, 32'd1);
      issue(INST_ADDI, 2, 0, 'h1FFF, 0, 0, 0, 2, 0, 1'b1, 1'b0, acc);
      clear_bus();
      sb.push_back('{0, 32'h2000, acc + LAT + 1});
      wait_idle("t3_idle");

      // shared tag 5 for both operands, top slot 7, wraparound add
      issue(INST_ADD, 5, 5, 0, 7, 0, 0, 5, 5, 1'b1, 1'b1, acc);
      @(posedge clk); #1;
      drive_slot(5, 32'hFFFF_FFFF);
      sb.push_back('{7, 32'hFFFF_FFFE, acc + 2 + LAT + 1});
      @(posedge clk); #1;
      clear_bus();
      wait_idle("t4_idle");

      // SUBI underflow: 3 - 5
      issue(INST_SUBI, 3, 0, 5, 3, 3, 0, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{3, 32'hFFFF_FFFE, acc + LAT + 1});
      wait_idle("t5_idle");

      // issue while busy is ignored
      issue(INST_ADD, 1, 2, 0, 5, 1, 1, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{5, 32'd2, acc + LAT + 1});
      inst_fu = FU; inst = enc(INST_ADD, 4, 4, 0); rbindex = 3'd6; vj = 50; vk = 50;
      @(posedge clk); #1;
      inst_fu = NO_FU;
      wait_idle("t6_idle");

      // issue to another unit is not ours
      inst_fu = 4'd1; inst = enc(INST_ADD, 8, 9, 0);
      #1;
      chk("t7_numj_other", numj, 0);
      @(posedge clk); #1;
      chk("t7_busy_other", busy, 0);
      inst_fu = NO_FU;

      // flush during EXEC, then a normal issue
      issue(INST_ADD, 1, 2, 0, 2, 4, 4, 0, 0, 1'b0, 1'b0, acc);
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      chk("t8_flush_busy", busy, 0);
      chk("t8_flush_valid", valid_out, '0);
      flush = 1'b0;
      #1;
      issue(INST_ADD, 1, 2, 0, 6, 100, 23, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{6, 32'd123, acc + LAT + 1});
      wait_idle("t8_idle");

      // flush during BCAST withdraws the broadcast
      issue(INST_ADD, 1, 2, 0, 1, 2, 3, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{1, 32'd5, acc + LAT + 1});
      repeat (LAT + 1) @(posedge clk);
      @(negedge clk); #1;
      chk("t9_in_bcast", valid_out, 8'b0000_0010);
      flush = 1'b1;
      #1;
      chk("t9_flush_busy", busy, 0);
      chk("t9_flush_valid", valid_out, '0);
      chk("t9_flush_data", data_out, '0);
      flush = 1'b0;
      issue(INST_ADD, 1, 2, 0, 0, 7, 8, 0, 0, 1'b0, 1'b0, acc);
      sb.push_back('{0, 32'd15, acc + LAT + 1});
      wait_idle("t9_idle");

      // reset in WAIT_OPS; the old tag arriving later must not broadcast
      issue(INST_ADD, 3, 4, 0, 2, 0, 9, 3, 0, 1'b1, 1'b0, acc);
      @(posedge clk); @(posedge clk); #1;
      chk("t10_waiting", busy, 1);
      reset = 1'b1;
      #1;
      chk("t10_reset_busy", busy, 0);
      chk("t10_reset_valid", valid_out, '0);
      chk("t10_reset_data", data_out, '0);
      reset = 1'b0;
      @(posedge clk); #1;
      drive_slot(3, 32'd77);
      @(posedge clk); #1;
      clear_bus();
      repeat (4) @(posedge clk);
      #1;
      chk("t10_stays_idle", busy, 0);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
